// File: rtl/modn_updown_counter.sv
// ---------------------------------------------------------------------------
// modn_updown_counter
//
// Programmable modulo up/down counter. The count range is 0..modulus
// inclusive. At the end of the range the counter either wraps (mode=0) or
// stops and raises a sticky done flag (mode=1). All state changes happen on
// the FALLING edge of clk. Reset is asynchronous and active-low.
//
// Parameters
//   WIDTH    counter width in bits (2..16)
//   INIT     count value forced while Reset is low
//
// Ports
//   clk      in   clock; state updates on negedge
//   Reset    in   asynchronous active-low reset
//   en       in   count enable
//   dir      in   1 = count down, 0 = count up
//   mode     in   0 = wrap at terminal, 1 = one-shot (stop at terminal)
//   load     in   synchronous load strobe (highest priority)
//   load_val in   value to load, clamped to modulus
//   modulus  in   top of the count range
//   count    out  current count (registered)
//   tc       out  one-clock terminal-count pulse (registered)
//   done     out  sticky one-shot completion flag (registered)
// ---------------------------------------------------------------------------
module modn_updown_counter #(
  parameter int                 WIDTH = 4,
  parameter logic [WIDTH-1:0]   INIT  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_reg, count_next;
  logic             tc_reg,    tc_next;
  logic             done_reg,  done_next;

  // Terminal detection. The up terminal uses >= so that a count sitting
  // above the modulus (after INIT or a modulus change) still terminates on
  // the next up step instead of running on to the natural wrap.
  logic             at_zero;
  logic             at_top;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_dec;
  logic [WIDTH-1:0] count_inc;

  assign at_zero      = (count_reg == ZERO);
  assign at_top       = (count_reg >= modulus);
  assign load_clamped = (load_val > modulus) ? modulus : load_val;

  // Both are only selected when they cannot overflow: decrement only when
  // count != 0, increment only when count < modulus (so count < all-ones).
  assign count_dec    = count_reg - ONE;
  assign count_inc    = count_reg + ONE;

  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    done_next  = done_reg;

    if (load) begin
      count_next = load_clamped;
      done_next  = 1'b0;
    end else if (done_reg) begin
      // One-shot finished: frozen until load or reset.
      count_next = count_reg;
    end else if (en) begin
      if (dir) begin
        if (at_zero) begin
          tc_next = 1'b1;
          if (mode) begin
            done_next = 1'b1;
          end else begin
            count_next = modulus;
          end
        end else begin
          count_next = count_dec;
        end
      end else begin
        if (at_top) begin
          tc_next = 1'b1;
          if (mode) begin
            done_next = 1'b1;
          end else begin
            count_next = ZERO;
          end
        end else begin
          count_next = count_inc;
        end
      end
    end
  end

  always_ff @(negedge clk or negedge Reset) begin
    if (!Reset) begin
      count_reg <= INIT;
      tc_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
      done_reg  <= done_next;
    end
  end

  assign count = count_reg;
  assign tc    = tc_reg;
  assign done  = done_reg;

endmodule

// File: doc/modn_updown_counter.md
MODN_UPDOWN_COUNTER -- requirements
Module: modn_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 SHALL have parameter INIT, default {WIDTH{1'b1}}, count value on reset.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the falling edge.
REQ-004 SHALL have port Reset  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port dir  input  1  direction: 1 = down, 0 = up.
REQ-007 SHALL have port mode  input  1  terminal behaviour: 0 = wrap, 1 = one-shot (stop).
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_val  input  WIDTH  value to load.
REQ-010 SHALL have port modulus  input  WIDTH  top of count range; range is 0..modulus inclusive.
REQ-011 SHALL have port count  output  WIDTH  current count, registered.
REQ-012 SHALL have port tc  output  1  terminal-count pulse, registered.
REQ-013 SHALL have port done  output  1  sticky one-shot completion flag, registered.

Function
REQ-014 SHALL evaluate one action per falling edge, priority: load > done-hold > en > idle.
REQ-015 On load: count <= min(load_val, modulus); done <= 0; tc <= 0; en ignored that edge.
REQ-016 Down step (dir=1, en=1), count != 0: count <= count - 1 (count > modulus also just decrements).
REQ-017 Down step, count == 0, mode=0: count <= modulus; tc <= 1.
REQ-018 Down step, count == 0, mode=1: count holds at 0; tc <= 1; done <= 1.
REQ-019 Up step (dir=0, en=1), count < modulus: count <= count + 1.
REQ-020 Up step, count >= modulus, mode=0: count <= 0; tc <= 1.
REQ-021 Up step, count >= modulus, mode=1: count holds; tc <= 1; done <= 1.
REQ-022 tc SHALL be high for exactly one clock after the edge that hit the terminal; 0 on every other edge.
REQ-023 While done=1, en and dir SHALL be ignored; count, done hold; tc = 0; only load or Reset clears done.
REQ-024 dir, mode, modulus SHALL take effect on the same edge they are sampled; no pipelining.
REQ-025 modulus = 0: count pinned at 0; every enabled step is terminal (tc every enabled edge in mode 0).
REQ-026 Arithmetic SHALL be WIDTH-bit unsigned; no intermediate overflow reaches count.
REQ-027 en=0 and load=0: all registers hold; tc <= 0.

Reset
REQ-028 Reset=0 SHALL immediately, without clk, force count = INIT, tc = 0, done = 0.
REQ-029 Reset mid-count or mid-load SHALL abandon the operation; first action after release on the next falling edge.
REQ-030 Reset deassertion SHALL NOT itself cause a count step, tc, or done.
REQ-031 INIT above modulus is legal; next step follows REQ-016/REQ-020.

Verification
REQ-032 WIDTH=4, Reset low then high, en=1, dir=1, mode=0, modulus=15: count 15,14..0,15; tc pulses once, the edge after count=0.
REQ-033 WIDTH=4, load=1 load_val=3, modulus=9, dir=0, mode=0, en=1: count 3..9,0,1; single tc pulse on the 9->0 edge.
REQ-034 mode=1, dir=1, load_val=2, en=1: count 2,1,0,0,0; tc one pulse; done=1 stays; then load_val=5 -> count=5, done=0.
REQ-035 load_val=12 with modulus=7: count=7; simultaneous load and en: load wins, no step.
REQ-036 Reset asserted between clock edges mid-count (count=6): count=INIT, tc=0, done=0 before the next edge.
REQ-037 modulus=0, mode=0, en=1 for 4 edges: count stays 0; tc high on all 4 edges.
